minimig_bank_arbiter: RTL

MINIMIG_BANK_ARBITER -- requirements
Module: minimig_bank_arbiter

---
 rtl/minimig_bank_arbiter_pkg.sv | 23 ++
 rtl/minimig_bank_arbiter_if.sv | 31 +++
 rtl/minimig_bank_arbiter_starve_ctr.sv | 20 ++
 rtl/minimig_bank_arbiter.sv | 109 ++++++++++
 4 files changed

// File: rtl/minimig_bank_arbiter_pkg.sv
// Shared types and constants for the Minimig chip/kick memory bank arbiter.
package minimig_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_ACK    = 2'd2
   } arb_state_e;

   localparam logic OWNER_CPU = 1'b0;
   localparam logic OWNER_DMA = 1'b1;

   localparam int BANK_KICK  = 7;
   localparam int BANK_KICKX = 6;
   localparam int BANK_CHIP  = 5;
   localparam int BANK_SLOW  = 4;

   // Writes into Kickstart space are dropped while the ROM is write protected.
   function automatic logic kick_discard(input logic we, input logic wp, input logic [7:0] bank);
      return wp && we && (bank[BANK_KICK] || bank[BANK_KICKX]);
   endfunction

endpackage

// File: rtl/minimig_bank_arbiter_if.sv
// Requester and memory-side signal bundle for the bank arbiter.
interface minimig_bank_arbiter_if;
   logic       cpu_req;
   logic       cpu_we;
   logic [7:0] cpu_bank;
   logic       cpu_ack;
   logic       cpu_nomem;
   logic       dma_req;
   logic       dma_we;
   logic [7:0] dma_bank;
   logic       dma_ack;
   logic       dma_nomem;
   logic       kick_wp;
   logic       mem_start;
   logic       mem_we;
   logic       mem_owner;
   logic [7:0] mem_bank;
   logic       busy;

   modport master (
      output cpu_req, cpu_we, cpu_bank, dma_req, dma_we, dma_bank, kick_wp,
      input  cpu_ack, cpu_nomem, dma_ack, dma_nomem,
      input  mem_start, mem_we, mem_owner, mem_bank, busy
   );

   modport slave (
      input  cpu_req, cpu_we, cpu_bank, dma_req, dma_we, dma_bank, kick_wp,
      output cpu_ack, cpu_nomem, dma_ack, dma_nomem,
      output mem_start, mem_we, mem_owner, mem_bank, busy
   );
endinterface

// File: rtl/minimig_bank_arbiter_starve_ctr.sv
// Saturating count of DMA grants made while the CPU was left waiting.
module minimig_arb_starve_ctr #(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic inc_i,
   input  logic clr_i,
   output logic sat_o
);
   logic [3:0] cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)               cnt_q <= '0;
      else if (clr_i)             cnt_q <= '0;
      else if (inc_i && !sat_o)   cnt_q <= cnt_q + 4'd1;
   end

   assign sat_o = (cnt_q == 4'(STARVE_MAX));
endmodule

// File: rtl/minimig_bank_arbiter.sv
// CPU/DMA arbiter for a single memory port: DMA priority with CPU anti-starvation,
// fixed-length memory cycles, and a one-cycle shortcut for empty or protected accesses.
module minimig_bank_arbiter
   import minimig_arb_pkg::*;
#(
   parameter int LAT        = 3,
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic reset_n,
   minimig_bank_arbiter_if.slave bus
);
   arb_state_e state_q;
   logic [3:0] lat_q;
   logic       cpu_ack_q, dma_ack_q, cpu_nomem_q, dma_nomem_q;
   logic       mem_start_q, mem_we_q, mem_owner_q, busy_q;
   logic [7:0] mem_bank_q;

   logic       starve_sat;
   logic       grant_cpu, grant_dma, sel_we, sel_nomem, sel_short;
   logic [7:0] sel_bank;

   always_comb begin
      grant_cpu = bus.cpu_req && (!bus.dma_req || starve_sat);
      grant_dma = bus.dma_req && !grant_cpu;
      sel_we    = grant_dma ? bus.dma_we   : bus.cpu_we;
      sel_bank  = grant_dma ? bus.dma_bank : bus.cpu_bank;
      sel_nomem = (sel_bank == 8'h00);
      sel_short = sel_nomem || kick_discard(sel_we, bus.kick_wp, sel_bank);
   end

   minimig_arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
      .clk     (clk),
      .reset_n (reset_n),
      .inc_i   ((state_q == ST_IDLE) && grant_dma && bus.cpu_req),
      .clr_i   ((state_q == ST_IDLE) && grant_cpu),
      .sat_o   (starve_sat)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         lat_q       <= '0;
         cpu_ack_q   <= 1'b0;
         dma_ack_q   <= 1'b0;
         cpu_nomem_q <= 1'b0;
         dma_nomem_q <= 1'b0;
         mem_start_q <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_owner_q <= 1'b0;
         mem_bank_q  <= '0;
         busy_q      <= 1'b0;
      end else begin
         mem_start_q <= 1'b0;
         cpu_ack_q   <= 1'b0;
         dma_ack_q   <= 1'b0;
         cpu_nomem_q <= 1'b0;
         dma_nomem_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (grant_cpu || grant_dma) begin
                  busy_q      <= 1'b1;
                  mem_we_q    <= sel_we;
                  mem_owner_q <= grant_dma ? OWNER_DMA : OWNER_CPU;
                  mem_bank_q  <= sel_bank;
                  if (sel_short) begin
                     state_q     <= ST_ACK;
                     cpu_ack_q   <= grant_cpu;
                     dma_ack_q   <= grant_dma;
                     cpu_nomem_q <= grant_cpu && sel_nomem;
                     dma_nomem_q <= grant_dma && sel_nomem;
                  end else begin
                     state_q     <= ST_ACCESS;
                     mem_start_q <= 1'b1;
                     lat_q       <= 4'(LAT - 1);
                  end
               end
            end
            ST_ACCESS: begin
               if (lat_q == 4'd0) begin
                  state_q   <= ST_ACK;
                  cpu_ack_q <= (mem_owner_q == OWNER_CPU);
                  dma_ack_q <= (mem_owner_q == OWNER_DMA);
               end else begin
                  lat_q <= lat_q - 4'd1;
               end
            end
            ST_ACK: begin
               state_q     <= ST_IDLE;
               busy_q      <= 1'b0;
               mem_we_q    <= 1'b0;
               mem_owner_q <= 1'b0;
               mem_bank_q  <= '0;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.cpu_ack   = cpu_ack_q;
   assign bus.dma_ack   = dma_ack_q;
   assign bus.cpu_nomem = cpu_nomem_q;
   assign bus.dma_nomem = dma_nomem_q;
   assign bus.mem_start = mem_start_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_owner = mem_owner_q;
   assign bus.mem_bank  = mem_bank_q;
   assign bus.busy      = busy_q;
endmodule
